// File: rtl/mem_port_arbiter.sv
// Shared instruction/data memory port arbiter with RW/MOC handshake.
// Optional MOC watchdog: define MEM_TIMEOUT_EN.
module mem_port_arbiter #(
  parameter int DATA_PRIORITY  = 1,
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        if_req,
  input  logic [31:0] if_addr,
  output logic        if_ack,
  output logic [31:0] if_rdata,
  input  logic        d_req,
  input  logic        d_rw,
  input  logic        d_size,
  input  logic [31:0] d_addr,
  input  logic [31:0] d_wdata,
  output logic        d_ack,
  output logic [31:0] d_rdata,
  output logic        mem_en,
  output logic        mem_rw,
  output logic        mem_size,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata,
  input  logic        mem_moc,
  output logic        busy,
  output logic        grant_d,
  output logic        err
);

  typedef enum logic [1:0] {
    IDLE,
    ACCESS,
    RESP
  } state_t;

  localparam logic DP = (DATA_PRIORITY != 0);

  state_t state, state_nx;

  logic        en_nx;
  logic        rw_nx;
  logic        size_nx;
  logic [31:0] addr_nx;
  logic [31:0] wdata_nx;
  logic        gd_nx;
  logic        if_ack_nx;
  logic        d_ack_nx;
  logic [31:0] if_rdata_nx;
  logic [31:0] d_rdata_nx;
  logic        busy_nx;
  logic        take_d;
  logic        take_f;

`ifdef MEM_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CW-1:0] LAST = CW'(TIMEOUT_CYCLES - 1);
  logic [CW-1:0] cnt, cnt_nx;
  logic          err_nx;
`else
  localparam int unused_timeout = TIMEOUT_CYCLES;
  assign err = 1'b0;
`endif

  logic unused_bits;
  assign unused_bits = ^if_addr[1:0];

  // tie-break: data wins under priority mode, else the port not served last
  assign take_d = d_req & (~if_req | DP | ~grant_d);
  assign take_f = if_req & ~take_d;

  // next-state and next-output decode
  always_comb begin
    state_nx    = state;
    en_nx       = mem_en;
    rw_nx       = mem_rw;
    size_nx     = mem_size;
    addr_nx     = mem_addr;
    wdata_nx    = mem_wdata;
    gd_nx       = grant_d;
    if_ack_nx   = 1'b0;
    d_ack_nx    = 1'b0;
    if_rdata_nx = if_rdata;
    d_rdata_nx  = d_rdata;
`ifdef MEM_TIMEOUT_EN
    cnt_nx      = cnt;
    err_nx      = 1'b0;
`endif
    unique case (state)
      IDLE: begin
        unique case (1'b1)
          take_d: begin
            state_nx = ACCESS;
            en_nx    = 1'b1;
            gd_nx    = 1'b1;
            rw_nx    = d_rw;
            size_nx  = d_size;
            wdata_nx = d_wdata;
            addr_nx  = d_size ? d_addr
                              : {d_addr[31:2], 2'b00};
`ifdef MEM_TIMEOUT_EN
            cnt_nx   = '0;
`endif
          end
          take_f: begin
            state_nx = ACCESS;
            en_nx    = 1'b1;
            gd_nx    = 1'b0;
            rw_nx    = 1'b1;
            size_nx  = 1'b0;
            wdata_nx = 32'h0;
            addr_nx  = {if_addr[31:2], 2'b00};
`ifdef MEM_TIMEOUT_EN
            cnt_nx   = '0;
`endif
          end
          default: ;
        endcase
      end
      ACCESS: begin
        if (mem_moc) begin
          state_nx  = RESP;
          en_nx     = 1'b0;
          d_ack_nx  = grant_d;
          if_ack_nx = ~grant_d;
          if (mem_rw) begin
            if (grant_d) d_rdata_nx = mem_rdata;
            else         if_rdata_nx = mem_rdata;
          end
`ifdef MEM_TIMEOUT_EN
        end else if (cnt == LAST) begin
          state_nx  = RESP;
          en_nx     = 1'b0;
          d_ack_nx  = grant_d;
          if_ack_nx = ~grant_d;
          err_nx    = 1'b1;
        end else begin
          cnt_nx = cnt + 1'b1;
`endif
        end
      end
      RESP: state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
    busy_nx = (state_nx != IDLE);
  end

  // state register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_nx;
  end

  // registered outputs
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      mem_en    <= 1'b0;
      mem_rw    <= 1'b0;
      mem_size  <= 1'b0;
      mem_addr  <= 32'h0;
      mem_wdata <= 32'h0;
      grant_d   <= 1'b0;
      if_ack    <= 1'b0;
      d_ack     <= 1'b0;
      if_rdata  <= 32'h0;
      d_rdata   <= 32'h0;
      busy      <= 1'b0;
    end else begin
      mem_en    <= en_nx;
      mem_rw    <= rw_nx;
      mem_size  <= size_nx;
      mem_addr  <= addr_nx;
      mem_wdata <= wdata_nx;
      grant_d   <= gd_nx;
      if_ack    <= if_ack_nx;
      d_ack     <= d_ack_nx;
      if_rdata  <= if_rdata_nx;
      d_rdata   <= d_rdata_nx;
      busy      <= busy_nx;
    end
  end

`ifdef MEM_TIMEOUT_EN
  // watchdog counter and error pulse
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt <= '0;
      err <= 1'b0;
    end else begin
      cnt <= cnt_nx;
      err <= err_nx;
    end
  end
`endif

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter.
// Second instance runs round-robin with MOC always high.
module tb_mem_port_arbiter;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        if_req = 1'b0;
  logic [31:0] if_addr = 32'h0;
  logic        d_req = 1'b0;
  logic        d_rw = 1'b1;
  logic        d_size = 1'b0;
  logic [31:0] d_addr = 32'h0;
  logic [31:0] d_wdata = 32'h0;
  logic        mem_moc = 1'b0;
  logic [31:0] mem_rdata = 32'h0;

  logic        if_ack, d_ack, mem_en, mem_rw, mem_size;
  logic        busy, grant_d, err;
  logic [31:0] if_rdata, d_rdata, mem_addr, mem_wdata;

  logic        r_if_ack, r_d_ack, r_en, r_rw, r_size;
  logic        r_busy, r_grant_d, r_err;
  logic [31:0] r_if_rdata, r_d_rdata, r_addr, r_wdata;
  logic        unused_r;

  int          moc_dly = 1;
  logic [31:0] rd_val = 32'h0;
  int          wcnt = 0;
  int          n_pass = 0;
  int          n_chk = 0;
  int          n;

  always #5 clk = ~clk;

  assign unused_r = ^{r_en, r_rw, r_size, r_busy, r_err,
                      r_addr, r_wdata};

  mem_port_arbiter #(.DATA_PRIORITY(1), .TIMEOUT_CYCLES(16)) u_dut (
    .clk(clk), .reset(reset),
    .if_req(if_req), .if_addr(if_addr),
    .if_ack(if_ack), .if_rdata(if_rdata),
    .d_req(d_req), .d_rw(d_rw), .d_size(d_size),
    .d_addr(d_addr), .d_wdata(d_wdata),
    .d_ack(d_ack), .d_rdata(d_rdata),
    .mem_en(mem_en), .mem_rw(mem_rw), .mem_size(mem_size),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_moc(mem_moc),
    .busy(busy), .grant_d(grant_d), .err(err)
  );

  mem_port_arbiter #(.DATA_PRIORITY(0), .TIMEOUT_CYCLES(16)) u_rr (
    .clk(clk), .reset(reset),
    .if_req(if_req), .if_addr(if_addr),
    .if_ack(r_if_ack), .if_rdata(r_if_rdata),
    .d_req(d_req), .d_rw(d_rw), .d_size(d_size),
    .d_addr(d_addr), .d_wdata(d_wdata),
    .d_ack(r_d_ack), .d_rdata(r_d_rdata),
    .mem_en(r_en), .mem_rw(r_rw), .mem_size(r_size),
    .mem_addr(r_addr), .mem_wdata(r_wdata),
    .mem_rdata(32'hCAFE0000), .mem_moc(1'b1),
    .busy(r_busy), .grant_d(r_grant_d), .err(r_err)
  );

  // memory model: MOC on the moc_dly-th ACCESS cycle, 0 = never
  always @(negedge clk) begin
    if (mem_en && moc_dly != 0) begin
      wcnt = wcnt + 1;
      mem_moc = (wcnt == moc_dly);
      mem_rdata = (wcnt == moc_dly) ? rd_val : 32'h0;
    end else begin
      wcnt = 0;
      mem_moc = 1'b0;
      mem_rdata = 32'h0;
    end
  end

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h, want %h", tag, got, exp);
  endtask

  // waits up to max negedges for an ack; n = negedges taken, 0 = none
  task automatic wait_for(input int sel, input int max, output int cnt);
    bit hit;
    cnt = 0;
    hit = 0;
    for (int i = 1; i <= max && !hit; i++) begin
      @(negedge clk);
      case (sel)
        0: hit = if_ack;
        1: hit = d_ack;
        default: hit = r_if_ack | r_d_ack;
      endcase
      if (hit) cnt = i;
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    repeat (2) @(negedge clk);
    chk("rst_en", mem_en, 0);
    chk("rst_busy", busy, 0);
    chk("rst_gd", grant_d, 0);
    chk("rst_addr", mem_addr, 0);
    chk("rst_if_rdata", if_rdata, 0);
    chk("rst_d_rdata", d_rdata, 0);
    chk("rst_err", err, 0);
    reset = 1'b1;

    moc_dly = 1; rd_val = 32'h8C220004;
    if_req = 1; if_addr = 32'h6;
    @(negedge clk);
    chk("t1_en", mem_en, 1);
    chk("t1_addr", mem_addr, 32'h4);
    chk("t1_rw", mem_rw, 1);
    chk("t1_size", mem_size, 0);
    chk("t1_busy", busy, 1);
    chk("t1_gd", grant_d, 0);
    wait_for(0, 8, n);
    chk("t1_lat", n, 1);
    chk("t1_rdata", if_rdata, 32'h8C220004);
    chk("t1_err", err, 0);
    chk("t1_dack", d_ack, 0);
    if_req = 0;
    @(negedge clk);
    chk("t1_pulse", if_ack, 0);
    chk("t1_idle", busy, 0);

    moc_dly = 2; rd_val = 32'h11112222;
    d_rw = 1; d_size = 0; d_addr = 32'h103; if_addr = 32'h208;
    if_req = 1; d_req = 1;
    wait_for(1, 10, n);
    chk("t2_dseen", n != 0, 1);
    chk("t2_gd1", grant_d, 1);
    chk("t2_drdata", d_rdata, 32'h11112222);
    chk("t2_noif", if_ack, 0);
    chk("t2_daddr", mem_addr, 32'h100);
    d_req = 0; rd_val = 32'h33334444;
    @(negedge clk);
    chk("t2_gap", busy, 0);
    wait_for(0, 10, n);
    chk("t2_fseen", n != 0, 1);
    chk("t2_gd0", grant_d, 0);
    chk("t2_ifrdata", if_rdata, 32'h33334444);
    chk("t2_faddr", mem_addr, 32'h208);
    if_req = 0;
    @(negedge clk);

    moc_dly = 5; rd_val = 32'hDEADBEEF;
    d_req = 1; d_rw = 0; d_size = 1;
    d_addr = 32'h13; d_wdata = 32'hAB;
    @(negedge clk);
    chk("t3_addr", mem_addr, 32'h13);
    chk("t3_size", mem_size, 1);
    chk("t3_rw", mem_rw, 0);
    chk("t3_wdata", mem_wdata, 32'hAB);
    d_addr = 32'hFFFF0000; d_wdata = 32'h55;
    d_rw = 1; d_size = 0;
    @(negedge clk);
    chk("t3_hold_addr", mem_addr, 32'h13);
    chk("t3_hold_wd", mem_wdata, 32'hAB);
    chk("t3_hold_rw", mem_rw, 0);
    wait_for(1, 10, n);
    chk("t3_lat", n, 4);
    chk("t3_rdata", d_rdata, 32'h11112222);
    d_req = 0;
    @(negedge clk);

    moc_dly = 0;
    if_req = 1; if_addr = 32'h40;
    @(negedge clk);
    chk("t4_en", mem_en, 1);
    #2 reset = 1'b0;
    #1;
    chk("t4_async_en", mem_en, 0);
    chk("t4_async_busy", busy, 0);
    chk("t4_async_rdata", if_rdata, 0);
    chk("t4_async_addr", mem_addr, 0);
    @(negedge clk);
    chk("t4_noack", if_ack, 0);
    moc_dly = 1; rd_val = 32'h00001234;
    reset = 1'b1;
    wait_for(0, 8, n);
    chk("t4_lat", n, 2);
    chk("t4_rdata", if_rdata, 32'h00001234);
    if_req = 0;
    @(negedge clk);

    reset = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    moc_dly = 1; rd_val = 32'h0;
    if_addr = 32'h200; d_addr = 32'h300; d_rw = 1;
    if_req = 1; d_req = 1;
    for (int k = 0; k < 4; k++) begin
      wait_for(2, 10, n);
      chk("t5_seen", n != 0, 1);
      chk("t5_rr_gd", r_grant_d, (k % 2 == 0));
      chk("t5_rr_dack", r_d_ack, (k % 2 == 0));
      chk("t5_rr_rdata", (k % 2 == 0) ? r_d_rdata : r_if_rdata,
          32'hCAFE0000);
      chk("t5_dp_dack", d_ack, 1);
      chk("t5_dp_gd", grant_d, 1);
    end
    if_req = 0; d_req = 0;
    repeat (4) @(negedge clk);

`ifdef MEM_TIMEOUT_EN
    moc_dly = 0;
    if_req = 1; if_addr = 32'h500;
    wait_for(0, 30, n);
    chk("t6_to_lat", n, 17);
    chk("t6_to_err", err, 1);
    chk("t6_to_rdata", if_rdata, 32'h0);
    chk("t6_to_en", mem_en, 0);
    if_req = 0;
    @(negedge clk);
    chk("t6_err_pulse", err, 0);
    moc_dly = 16; rd_val = 32'h0BADF00D;
    if_req = 1;
    wait_for(0, 30, n);
    chk("t6_edge_lat", n, 17);
    chk("t6_edge_err", err, 0);
    chk("t6_edge_rdata", if_rdata, 32'h0BADF00D);
    if_req = 0;
    @(negedge clk);
`endif

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
